// File: rtl/bus_traffic_pkg.sv
// Shared definitions for the bus traffic master.
//   state_t           : transaction sequencer states
//   MODE_ALT/WR/RD    : command pattern selectors for the MODE parameter
//   CMD_RD/CMD_WR     : encodings driven on the cmd handshake line
package bus_traffic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    REQ,
    RELEASE,
    NEXT,
    DONE
  } state_t;

  localparam int unsigned MODE_ALT = 0;
  localparam int unsigned MODE_WR  = 1;
  localparam int unsigned MODE_RD  = 2;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

endpackage

// File: rtl/bus_pattern_gen.sv
// Address / data / command pattern source for transaction index k.
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart the pattern at k = 0
//   advance  : step to k + 1
//   addr     : {k[1], k*(ADDR_STEP>>SHIFT)} truncated to ADDR_W
//   wdata    : k*DATA_STEP on writes, 0 on reads
//   cmd      : read/write selection for k according to MODE
module bus_pattern_gen
  import bus_traffic_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] ADDR_STEP = 32'hCE2,
  parameter int unsigned SHIFT     = 0,
  parameter logic [31:0] DATA_STEP = 32'h345,
  parameter int unsigned MODE      = MODE_ALT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              cmd
);

  localparam logic [ADDR_W-2:0] ADDR_INC = (ADDR_W-1)'(ADDR_STEP >> SHIFT);
  localparam logic [DATA_W-1:0] DATA_INC = DATA_W'(DATA_STEP);

  // Only k[1:0] ever reaches the outputs, so the index is kept modulo 4.
  logic [1:0]        k;
  // The address MSB comes from k[1], so the accumulator is one bit narrower.
  logic [ADDR_W-2:0] addr_acc;
  logic [DATA_W-1:0] data_acc;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      k        <= '0;
      addr_acc <= '0;
      data_acc <= '0;
    end else if (advance) begin
      k        <= k + 2'd1;
      addr_acc <= addr_acc + ADDR_INC;
      data_acc <= data_acc + DATA_INC;
    end
  end

  // MODE=3 (and anything else unrecognised) falls back to alternating.
  always_comb begin
    cmd = k[0];
    if (MODE == MODE_WR) begin
      cmd = CMD_WR;
    end else if (MODE == MODE_RD) begin
      cmd = CMD_RD;
    end
  end

  assign addr  = {k[1], addr_acc};
  assign wdata = (cmd == CMD_WR) ? data_acc : '0;

endmodule

// File: rtl/bus_traffic_master.sv
// Programmable four-phase req/ack bus master for bus-level stress benches.
// Issues NUM_TXN (or, with 0, an unbounded stream until stop) reads/writes
// with generated address and data patterns, captures read data and reports
// completion, timeouts and the number of finished transactions.
//   clk, rst  : clock, synchronous active-high reset
//   start     : one-cycle pulse, starts a run from idle
//   stop      : finish the current transaction, then end the run
//   ack/rdata : slave handshake and read data (valid while ack = 1)
//   req/cmd/addr/wdata : request, 1 = write, address, write data
//   busy/done : run in progress, one-cycle end-of-run pulse
//   err       : sticky timeout flag, cleared by start
//   rd_valid/rd_data : one-cycle capture pulse and captured read data
//   txn_cnt   : completed transactions in this run
module bus_traffic_master
  import bus_traffic_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] ADDR_STEP = 32'hCE2,
  parameter int unsigned SHIFT     = 0,
  parameter logic [31:0] DATA_STEP = 32'h345,
  parameter int unsigned NUM_TXN   = 4,
  parameter int unsigned MODE      = MODE_ALT,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              ack,
  input  logic [DATA_W-1:0] rdata,
  output logic              req,
  output logic              cmd,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [15:0]       txn_cnt
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
  localparam logic [15:0] TXN_LAST = 16'(NUM_TXN - 1);

  state_t            state;
  state_t            state_next;
  logic [31:0]       tmo_cnt;
  logic              tmo_hit;
  logic              timeout;
  logic              stop_lat;
  logic              last_txn;
  logic              drive;
  logic              gen_clear;
  logic              gen_advance;
  logic              rd_hit;
  logic [ADDR_W-1:0] gen_addr;
  logic [DATA_W-1:0] gen_wdata;
  logic              gen_cmd;

  bus_pattern_gen #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .ADDR_STEP (ADDR_STEP),
    .SHIFT     (SHIFT),
    .DATA_STEP (DATA_STEP),
    .MODE      (MODE)
  ) u_pattern (
    .clk     (clk),
    .rst     (rst),
    .clear   (gen_clear),
    .advance (gen_advance),
    .addr    (gen_addr),
    .wdata   (gen_wdata),
    .cmd     (gen_cmd)
  );

  // tmo_cnt counts cycles already spent in the current REQ/RELEASE visit,
  // so hitting TIMEOUT-1 here means this is the TIMEOUT-th waiting cycle.
  assign tmo_hit     = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
  assign last_txn    = (NUM_TXN != 0) && (txn_cnt == TXN_LAST);
  assign gen_clear   = (state == IDLE) && start;
  assign gen_advance = (state == NEXT);
  assign rd_hit      = (state == REQ) && ack && (gen_cmd == CMD_RD);

  always_comb begin
    state_next = state;
    req        = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    drive      = 1'b1;
    timeout    = 1'b0;
    unique case (state)
      IDLE: begin
        busy  = 1'b0;
        drive = 1'b0;
        if (start) state_next = SETUP;
      end
      SETUP: state_next = REQ;
      REQ: begin
        req = 1'b1;
        if (ack) begin
          state_next = RELEASE;
        end else if (tmo_hit) begin
          timeout    = 1'b1;
          state_next = DONE;
        end
      end
      RELEASE: begin
        if (!ack) begin
          state_next = NEXT;
        end else if (tmo_hit) begin
          timeout    = 1'b1;
          state_next = DONE;
        end
      end
      NEXT: begin
        if (last_txn || stop_lat || stop) state_next = DONE;
        else                              state_next = SETUP;
      end
      DONE: begin
        drive      = 1'b0;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tmo_cnt  <= '0;
      stop_lat <= 1'b0;
      err      <= 1'b0;
      txn_cnt  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state <= state_next;

      if (state_next != state)                 tmo_cnt <= '0;
      else if (state == REQ || state == RELEASE) tmo_cnt <= tmo_cnt + 32'd1;

      if (state == IDLE) stop_lat <= 1'b0;
      else if (stop)     stop_lat <= 1'b1;

      if (gen_clear) begin
        err     <= 1'b0;
        txn_cnt <= '0;
      end else begin
        if (timeout)     err     <= 1'b1;
        if (gen_advance) txn_cnt <= txn_cnt + 16'd1;
      end

      rd_valid <= rd_hit;
      if (rd_hit) rd_data <= rdata;
    end
  end

  // Pattern outputs are only presented while a transaction is in flight,
  // which keeps them at zero in IDLE/DONE and straight after reset.
  assign cmd   = drive ? gen_cmd   : 1'b0;
  assign addr  = drive ? gen_addr  : '0;
  assign wdata = drive ? gen_wdata : '0;

endmodule
